ysyx_25020047_mem_arb: RTL and testbench
========================================

# ysyx_25020047_mem_arb

Two-requester arbiter that shares the core's single data-memory port between the instruction fetch unit (read-only) and the load/store unit (read or masked write). It sits between IFU/LSU and the memory/bus bridge. It serialises one outstanding transaction at a time, applies round-robin on contention, and returns an error response if memory does not answer within a bounded number of cycles.

## Interface
- TIMEOUT_CYCLES, default 255: cycles waited in RSP before a timeout error response is generated (1..65535).
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  IFU read address.
- ifu_rsp_valid  out  1  one-cycle response pulse to IFU.
- ifu_rsp_data  out  32  read data to IFU.
- ifu_rsp_err  out  1  error/timeout flag to IFU.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  32  pre-aligned write data.
- lsu_wmask  in  4  byte-enable mask.
- lsu_rsp_valid  out  1  one-cycle response pulse to LSU.
- lsu_rsp_data  out  32  read data to LSU (0 for writes).
- lsu_rsp_err  out  1  error/timeout flag to LSU.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr, mem_wdata  out  32  latched request fields.
- mem_wen  out  1;  mem_wmask  out  4  latched request fields (wmask forced 0 for reads).
- mem_rsp_valid  in  1  memory response (no backpressure).
- mem_rsp_data  in  32;  mem_rsp_err  in  1  memory response fields.

## Operation
- States: IDLE, REQ, RSP. Registers: state, owner (0=IFU, 1=LSU), last_grant, latched addr/wen/wdata/wmask, timeout counter (16 bit).
- IDLE: grant computed combinationally. One valid -> that requester wins. Both valid -> the one not equal to last_grant wins. Only the winner sees req_ready=1; both readies 0 outside IDLE.
- Handshake (valid&&ready in IDLE): latch fields. For IFU, wen=0 and wmask=0. Set owner and last_grant to the winner, then go to REQ.
- REQ: mem_req_valid=1 with latched fields held stable. On mem_req_ready -> RSP, counter cleared to 0.
- RSP: counter increments each cycle. On mem_rsp_valid, owner's rsp_valid=1 with data/err passed through combinationally, then go to IDLE. Non-owner rsp_valid stays 0.
- Timeout: in RSP with counter==TIMEOUT_CYCLES and no mem_rsp_valid, owner's rsp_valid=1, err=1, data=0, then go to IDLE. mem_rsp_valid in the same cycle takes precedence over timeout.
- mem_rsp_valid in IDLE or REQ (stray/late response) is ignored and never forwarded.
- Write responses forward mem_rsp_err; rsp_data is forced to 0 when the latched wen=1.
- Request inputs are sampled only at handshake; later changes do not affect the in-flight transaction.

## Timing
- Reset (async, immediate): state=IDLE, last_grant=IFU (first tie goes to LSU), counter=0, latched fields 0. While rst is high all outputs are 0, including both req_ready.
- Minimum latency: handshake at cycle t; mem_req_valid at t+1; if mem_req_ready at t+1 and mem_rsp_valid at t+2, rsp_valid at t+2 and the next request is accepted at t+3.
- Throughput: at most one transaction every 3 cycles. No overlap of outstanding requests.
- Timeout fires TIMEOUT_CYCLES+1 cycles after entering RSP.
- Reset mid-transaction aborts it. No response is issued, and a later mem_rsp_valid is ignored (IDLE).

## Test plan
- Single IFU read, addr 0x80000000, memory returns 0x00000413 one cycle after accept -> ifu_rsp_valid pulse with data 0x00000413 and err=0; lsu_rsp_valid stays 0.
- Both valid from reset, continuously -> grants alternate LSU, IFU, LSU, IFU; each requester completes exactly 4 transactions out of 8.
- LSU sb: addr 0x80001003, wdata 0xAB000000, wmask 0x8 -> mem_wen=1, mem_wmask=0x8, mem_wdata=0xAB000000; response data=0 even if mem_rsp_data=0xFFFFFFFF.
- Memory holds mem_req_ready=0 for 10 cycles -> mem_req_valid and fields stay stable for all 10 cycles; no rsp_valid; no second grant.
- TIMEOUT_CYCLES=4, memory never responds -> owner rsp_valid with err=1 and data=0 exactly 5 cycles after entering RSP. A late mem_rsp_valid 2 cycles later is not forwarded.
- Assert rst while in RSP, then mem_rsp_valid after release -> no rsp_valid on either side; state is IDLE and the next IFU request is granted normally.

Source files
------------

// File: rtl/ysyx_25020047_mem_arb.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU.
// Ports: IFU req/rsp, LSU req/rsp, memory req/rsp; one transaction in flight.
module ysyx_25020047_mem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic        owner;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [3:0]  wmask_q;
  logic [15:0] cnt;

  logic        gnt_lsu;
  logic        hs;
  logic        rsp_fire;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // On a tie the requester that did not win last time is served.
  assign gnt_lsu = lsu_req_valid &&
                   (!ifu_req_valid || !last_grant);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wen   = wen_q;
  assign mem_wmask = wmask_q;

  always_comb begin
    state_n       = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;
    rsp_data      = 32'h0;
    rsp_err       = 1'b0;
    unique case (state)
      IDLE: begin
        // Readies are gated so nothing is accepted while reset is held.
        if (!rst) begin
          ifu_req_ready = ifu_req_valid && !gnt_lsu;
          lsu_req_ready = gnt_lsu;
        end
        if (ifu_req_ready || lsu_req_ready)
          state_n = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_n = RSP;
      end
      RSP: begin
        // A real response wins over a timeout in the same cycle.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = wen_q ? 32'h0 : mem_rsp_data;
          rsp_err  = mem_rsp_err;
          state_n  = IDLE;
        end else if (cnt == TMO) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign hs = ifu_req_ready || lsu_req_ready;

  assign ifu_rsp_valid = rsp_fire && !owner;
  assign ifu_rsp_data  = ifu_rsp_valid ? rsp_data : 32'h0;
  assign ifu_rsp_err   = ifu_rsp_valid && rsp_err;
  assign lsu_rsp_valid = rsp_fire && owner;
  assign lsu_rsp_data  = lsu_rsp_valid ? rsp_data : 32'h0;
  assign lsu_rsp_err   = lsu_rsp_valid && rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wen_q      <= 1'b0;
      wmask_q    <= 4'h0;
      cnt        <= 16'h0;
    end else begin
      state <= state_n;
      if (hs) begin
        owner      <= lsu_req_ready;
        last_grant <= lsu_req_ready;
        addr_q     <= lsu_req_ready ? lsu_addr : ifu_addr;
        wen_q      <= lsu_req_ready && lsu_wen;
        wdata_q    <= lsu_req_ready ? lsu_wdata : 32'h0;
        wmask_q    <= (lsu_req_ready && lsu_wen) ?
                      lsu_wmask : 4'h0;
      end
      if (state == REQ)
        cnt <= 16'h0;
      else if (state == RSP)
        cnt <= cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Directed testbench for ysyx_25020047_mem_arb.
// Immediate-assertion checks on hand-computed expectations.
module tb_ysyx_25020047_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;

  int passed = 0;
  int total  = 0;
  int n_ifu  = 0;
  int n_lsu  = 0;

  always #5 clk = ~clk;

  ysyx_25020047_mem_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wen(mem_wen),
    .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_err   = 1'b0;

    // Reset state: everything quiet even with requests pending.
    nxt();
    chk("rst_ifu_ready", 32'(ifu_req_ready), 32'h0);
    chk("rst_lsu_ready", 32'(lsu_req_ready), 32'h0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b0;

    // Single IFU read.
    nxt();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    settle();
    chk("t1_ifu_ready", 32'(ifu_req_ready), 32'h1);
    chk("t1_lsu_ready", 32'(lsu_req_ready), 32'h0);
    nxt();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'h1234_5678;
    mem_req_ready = 1'b1;
    settle();
    chk("t1_mem_valid", 32'(mem_req_valid), 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_mem_wen", 32'(mem_wen), 32'h0);
    chk("t1_mem_wmask", 32'(mem_wmask), 32'h0);
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0413;
    settle();
    chk("t1_rsp_valid", 32'(ifu_rsp_valid), 32'h1);
    chk("t1_rsp_data", ifu_rsp_data, 32'h0000_0413);
    chk("t1_rsp_err", 32'(ifu_rsp_err), 32'h0);
    chk("t1_lsu_quiet", 32'(lsu_rsp_valid), 32'h0);
    nxt();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t1_rsp_pulse", 32'(ifu_rsp_valid), 32'h0);
    chk("t1_idle_mem", 32'(mem_req_valid), 32'h0);

    // Contention from reset: first tie to LSU, then alternate.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    lsu_addr      = 32'h8000_2000;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_lsu_grant", 32'(lsu_req_ready),
          (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("t2_ifu_grant", 32'(ifu_req_ready),
          (i % 2 == 0) ? 32'h0 : 32'h1);
      nxt();
      mem_req_ready = 1'b1;
      settle();
      chk("t2_mem_addr", mem_addr,
          (i % 2 == 0) ? 32'h8000_2000 : 32'h8000_0100);
      nxt();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h100 + i;
      settle();
      n_ifu += int'(ifu_rsp_valid);
      n_lsu += int'(lsu_rsp_valid);
      if (i % 2 == 0)
        chk("t2_lsu_data", lsu_rsp_data, 32'h100 + i);
      else
        chk("t2_ifu_data", ifu_rsp_data, 32'h100 + i);
      nxt();
      mem_rsp_valid = 1'b0;
    end
    chk("t2_ifu_count", 32'(n_ifu), 32'd4);
    chk("t2_lsu_count", 32'(n_lsu), 32'd4);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // LSU byte store; write response data forced to 0.
    nxt();
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b1;
    lsu_addr      = 32'h8000_1003;
    lsu_wdata     = 32'hAB00_0000;
    lsu_wmask     = 4'h8;
    settle();
    chk("t3_lsu_ready", 32'(lsu_req_ready), 32'h1);
    nxt();
    lsu_req_valid = 1'b0;
    lsu_wdata     = 32'h5555_5555;
    lsu_wmask     = 4'hF;
    mem_req_ready = 1'b1;
    settle();
    chk("t3_mem_wen", 32'(mem_wen), 32'h1);
    chk("t3_mem_wmask", 32'(mem_wmask), 32'h8);
    chk("t3_mem_wdata", mem_wdata, 32'hAB00_0000);
    chk("t3_mem_addr", mem_addr, 32'h8000_1003);
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    settle();
    chk("t3_rsp_valid", 32'(lsu_rsp_valid), 32'h1);
    chk("t3_rsp_data", lsu_rsp_data, 32'h0);
    chk("t3_rsp_err", 32'(lsu_rsp_err), 32'h0);
    nxt();
    mem_rsp_valid = 1'b0;
    lsu_wen       = 1'b0;

    // Memory stalls the request for 10 cycles.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    settle();
    chk("t4_ifu_ready", 32'(ifu_req_ready), 32'h1);
    nxt();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t4_mem_valid", 32'(mem_req_valid), 32'h1);
      chk("t4_mem_addr", mem_addr, 32'h8000_0010);
      chk("t4_no_grant", 32'(lsu_req_ready), 32'h0);
      chk("t4_no_rsp", 32'(ifu_rsp_valid), 32'h0);
      nxt();
    end
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_00AA;
    settle();
    chk("t4_rsp_data", ifu_rsp_data, 32'h0000_00AA);
    nxt();
    mem_rsp_valid = 1'b0;

    // Timeout with TIMEOUT_CYCLES=4: fires on 5th RSP cycle.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0020;
    nxt();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t5_wait", 32'(ifu_rsp_valid), 32'h0);
      nxt();
    end
    settle();
    chk("t5_tmo_valid", 32'(ifu_rsp_valid), 32'h1);
    chk("t5_tmo_err", 32'(ifu_rsp_err), 32'h1);
    chk("t5_tmo_data", ifu_rsp_data, 32'h0);
    nxt();
    nxt();
    mem_rsp_valid = 1'b1;
    settle();
    chk("t5_late_ifu", 32'(ifu_rsp_valid), 32'h0);
    chk("t5_late_lsu", 32'(lsu_rsp_valid), 32'h0);
    nxt();
    mem_rsp_valid = 1'b0;

    // Reset while in RSP aborts the transaction.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0030;
    nxt();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    settle();
    chk("t6_rst_mem", 32'(mem_req_valid), 32'h0);
    chk("t6_rst_rsp", 32'(ifu_rsp_valid), 32'h0);
    nxt();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    chk("t6_stray_ifu", 32'(ifu_rsp_valid), 32'h0);
    chk("t6_stray_lsu", 32'(lsu_rsp_valid), 32'h0);
    chk("t6_idle_mem", 32'(mem_req_valid), 32'h0);
    nxt();
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    settle();
    chk("t6_regrant", 32'(ifu_req_ready), 32'h1);
    nxt();
    ifu_req_valid = 1'b0;
    settle();
    chk("t6_mem_valid", 32'(mem_req_valid), 32'h1);
    chk("t6_mem_addr", mem_addr, 32'h8000_0040);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
